// File: rtl/ds_data_distributing.sv
// Downstream data distributor.
// Parses a merged 128-bit beat stream made of [header, payload...] frames.
// Payload beats are steered to one of TOTAL_NUM channel caches through a
// one-hot write enable. Beats for out-of-range channels are consumed and
// discarded. The block also tracks frame count, header errors and frame
// sequence gaps.
module ds_data_distributing #(
  parameter int          TOTAL_NUM = 104,
  parameter logic [15:0] HDR_MAGIC = 16'hEB90
) (
  input  logic                 sys_clk_i,
  input  logic                 rst_i,
  input  logic                 ds_flow_vld_i,
  input  logic [127:0]         ds_flow_i,
  output logic                 ds_flow_rdy_o,
  output logic [TOTAL_NUM-1:0] ds_timming_wr_en_o,
  output logic [127:0]         ds_timming_din_o,
  input  logic [TOTAL_NUM-1:0] ds_timming_prog_full_i,
  output logic                 frame_done_pluse_o,
  output logic [15:0]          frame_cnt_o,
  output logic [15:0]          hdr_err_cnt_o,
  output logic                 seq_err_o
);

  // The channel count is widened to 9 bits so that TOTAL_NUM = 256 still compares correctly.
  localparam logic [8:0] LP_TOTAL_NUM = 9'(TOTAL_NUM);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DROP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_run;         // rises on the first edge after reset
  logic [7:0]            r_ch;
  logic [11:0]           r_len;
  logic [11:0]           r_beat_cnt;
  logic [15:0]           r_frame_cnt;
  logic                  r_have_prev;   // a valid frame count has been seen since reset
  logic                  r_seq_err;
  logic [15:0]           r_hdr_err_cnt;
  logic [TOTAL_NUM-1:0]  r_wr_en;
  logic [127:0]          r_din;
  logic                  r_done;

  logic [15:0]           w_hdr_magic;
  logic [7:0]            w_hdr_ch;
  logic [11:0]           w_hdr_len;
  logic [15:0]           w_hdr_fcnt;
  logic                  w_magic_ok;
  logic                  w_ch_ok;
  logic                  w_len_nz;
  logic [TOTAL_NUM-1:0]  w_ch_sel;
  logic                  w_full_sel;
  logic                  w_acc;
  logic                  w_beat_last;

  assign w_hdr_magic = ds_flow_i[127:112];
  assign w_hdr_ch    = ds_flow_i[111:104];
  assign w_hdr_len   = ds_flow_i[103:92];
  assign w_hdr_fcnt  = ds_flow_i[91:76];
  assign w_magic_ok  = (w_hdr_magic == HDR_MAGIC);
  assign w_ch_ok     = ({1'b0, w_hdr_ch} < LP_TOTAL_NUM);
  assign w_len_nz    = (w_hdr_len != 12'd0);

  // One decoder bit per channel; it is reused for backpressure select and write enable.
  genvar gi;
  generate
    for (gi = 0; gi < TOTAL_NUM; gi++) begin : g_ch_sel
      assign w_ch_sel[gi] = ({1'b0, r_ch} == 9'(gi));
    end
  endgenerate

  assign w_full_sel    = |(ds_timming_prog_full_i & w_ch_sel);
  assign ds_flow_rdy_o = r_run & ~((r_state == S_PAYLOAD) & w_full_sel);
  assign w_acc         = ds_flow_vld_i & ds_flow_rdy_o;
  assign w_beat_last   = ((r_beat_cnt + 12'd1) == r_len);

  // State register.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state: parse headers in idle; leave payload/drop after the last counted beat.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && w_magic_ok && w_len_nz)
          w_state_next = w_ch_ok ? S_PAYLOAD : S_DROP;
      end
      S_PAYLOAD, S_DROP: begin
        if (w_acc && w_beat_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch header fields, count beats, register writes and status.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_run         <= 1'b0;
      r_ch          <= '0;
      r_len         <= '0;
      r_beat_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_have_prev   <= 1'b0;
      r_seq_err     <= 1'b0;
      r_hdr_err_cnt <= '0;
      r_wr_en       <= '0;
      r_din         <= '0;
      r_done        <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_wr_en <= '0;
      r_done  <= 1'b0;
      if (w_acc) begin
        case (r_state)
          S_IDLE: begin
            r_beat_cnt <= '0;
            if (!w_magic_ok || (!w_ch_ok && w_len_nz)) begin
              if (r_hdr_err_cnt != 16'hFFFF) r_hdr_err_cnt <= r_hdr_err_cnt + 16'd1;
            end
            if (w_magic_ok && w_len_nz) r_len <= w_hdr_len;
            if (w_magic_ok && w_len_nz && w_ch_ok) begin
              r_ch        <= w_hdr_ch;
              r_frame_cnt <= w_hdr_fcnt;
              r_have_prev <= 1'b1;
              if (r_have_prev && (w_hdr_fcnt != (r_frame_cnt + 16'd1))) r_seq_err <= 1'b1;
            end
          end
          S_PAYLOAD: begin
            r_wr_en    <= w_ch_sel;
            r_din      <= ds_flow_i;
            r_done     <= w_beat_last;
            r_beat_cnt <= w_beat_last ? 12'd0 : (r_beat_cnt + 12'd1);
          end
          S_DROP: begin
            r_beat_cnt <= w_beat_last ? 12'd0 : (r_beat_cnt + 12'd1);
          end
          default: r_beat_cnt <= '0;
        endcase
      end
    end
  end

  assign ds_timming_wr_en_o = r_wr_en;
  assign ds_timming_din_o   = r_din;
  assign frame_done_pluse_o = r_done;
  assign frame_cnt_o        = r_frame_cnt;
  assign hdr_err_cnt_o      = r_hdr_err_cnt;
  assign seq_err_o          = r_seq_err;

endmodule

// File: tb/tb_ds_data_distributing.sv
// Self-checking bench for ds_data_distributing.
// A frame-level reference model tracks beats remaining in the current frame
// and predicts ready, writes and status every cycle. Directed scenarios also
// pin the results to hand-computed values.
module tb_ds_data_distributing;
  localparam int          TN    = 104;
  localparam logic [15:0] MAGIC = 16'hEB90;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0;
  logic [127:0]  data = '0;
  logic          rdy;
  logic [TN-1:0] wr_en;
  logic [127:0]  din;
  logic [TN-1:0] pf = '0;
  logic          done;
  logic [15:0]   fcnt_o;
  logic [15:0]   err_o;
  logic          seq_o;

  ds_data_distributing #(.TOTAL_NUM(TN), .HDR_MAGIC(MAGIC)) dut (
    .sys_clk_i              (clk),
    .rst_i                  (rst),
    .ds_flow_vld_i          (vld),
    .ds_flow_i              (data),
    .ds_flow_rdy_o          (rdy),
    .ds_timming_wr_en_o     (wr_en),
    .ds_timming_din_o       (din),
    .ds_timming_prog_full_i (pf),
    .frame_done_pluse_o     (done),
    .frame_cnt_o            (fcnt_o),
    .hdr_err_cnt_o          (err_o),
    .seq_err_o              (seq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit pf_random = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Observed writes, recorded from the DUT outputs.
  int           obs_ch[$];
  logic [127:0] obs_d[$];
  bit           obs_done[$];
  int           n_done = 0;

  // Reference model: what kind of beat comes next and how many beats remain.
  int          m_kind = 0;      // 0 header expected, 1 payload to a channel, 2 payload dropped
  int          m_left = 0;
  int          m_ch = 0;
  bit          m_started = 1'b0;
  logic [15:0] m_err = '0;
  logic [15:0] m_fcnt = '0;
  bit          m_have = 1'b0;
  bit          m_seq = 1'b0;
  int          exp_wr = -1;
  logic [127:0] exp_din = '0;
  bit          exp_done = 1'b0;

  // Per-cycle compare and model step; inputs are stable here up to the next rising edge.
  always @(negedge clk) begin
    logic          exp_rdy;
    logic [TN-1:0] ew;
    int            nwr;
    logic [127:0]  ndin;
    bit            ndone;
    int            hch;
    int            hlen;
    logic [15:0]   hfc;
    if (rst) begin
      chk("rst_rdy", rdy, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_din", din, 0);
      chk("rst_done", done, 0);
      chk("rst_frame_cnt", fcnt_o, 0);
      chk("rst_hdr_err", err_o, 0);
      chk("rst_seq_err", seq_o, 0);
      m_kind = 0; m_left = 0; m_ch = 0; m_started = 1'b0;
      m_err = '0; m_fcnt = '0; m_have = 1'b0; m_seq = 1'b0;
      exp_wr = -1; exp_din = '0; exp_done = 1'b0;
    end else begin
      ew = '0;
      if (exp_wr >= 0) ew[exp_wr] = 1'b1;
      chk("wr_en", wr_en, ew);
      if (exp_wr >= 0) chk("din", din, exp_din);
      chk("frame_done", done, exp_done);
      chk("frame_cnt", fcnt_o, m_fcnt);
      chk("hdr_err_cnt", err_o, m_err);
      chk("seq_err", seq_o, m_seq);
      exp_rdy = m_started && !(m_kind == 1 && pf[m_ch]);
      chk("rdy", rdy, exp_rdy);

      if (|wr_en) begin
        int c;
        c = -1;
        for (int i = 0; i < TN; i++) if (wr_en[i]) c = i;
        obs_ch.push_back(c);
        obs_d.push_back(din);
        obs_done.push_back(done);
      end
      if (done) n_done++;

      nwr = -1; ndin = exp_din; ndone = 1'b0;
      if (vld && exp_rdy) begin
        if (m_kind == 0) begin
          hch  = int'(data[111:104]);
          hlen = int'(data[103:92]);
          hfc  = data[91:76];
          if (data[127:112] != MAGIC) begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
          end else if (hlen == 0) begin
            // empty frame: ignored entirely
          end else if (hch >= TN) begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
            m_kind = 2; m_left = hlen;
          end else begin
            m_kind = 1; m_left = hlen; m_ch = hch;
            if (m_have && hfc != m_fcnt + 16'd1) m_seq = 1'b1;
            m_fcnt = hfc; m_have = 1'b1;
          end
        end else begin
          if (m_kind == 1) begin
            nwr = m_ch; ndin = data;
          end
          m_left--;
          if (m_left == 0) begin
            ndone = (m_kind == 1);
            m_kind = 0;
          end
        end
      end
      exp_wr = nwr; exp_din = ndin; exp_done = ndone;
      m_started = 1'b1;
    end
  end

  // Random almost-full pattern while enabled.
  always @(posedge clk) begin
    #1;
    if (pf_random) for (int i = 0; i < TN; i++) pf[i] = (($urandom % 4) == 0);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] hdr(input logic [15:0] mg, input logic [7:0] ch,
                                       input logic [11:0] len, input logic [15:0] fc);
    logic [75:0] r;
    r = 76'({$urandom, $urandom, $urandom});
    return {mg, ch, len, fc, r};
  endfunction

  task automatic clear_obs();
    obs_ch.delete(); obs_d.delete(); obs_done.delete(); n_done = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    clear_obs();
  endtask

  // Present one beat and hold it until the handshake completes (bounded).
  task automatic send(input logic [127:0] d);
    int   n;
    logic a;
    n = 0; a = 1'b0;
    vld = 1'b1; data = d;
    while (!a && n < 500) begin
      @(negedge clk); a = rdy;
      @(posedge clk); #1;
      n++;
    end
    if (!a) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: got rdy low for %0d cycles required accept", n);
    end
    vld = 1'b0; data = rnd128();
  endtask

  initial begin
    logic [127:0] a_b, b_b, c_b, d_b;
    logic [15:0]  fc_run;
    int           t0;

    rst = 1'b1;
    idle(2);
    do_reset();

    // Channel 5, three beats.
    $display("scenario ch5 len3");
    a_b = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
    b_b = 128'hBBBB_0000_1111_2222_3333_4444_5555_6666;
    c_b = 128'hCCCC_0000_1111_2222_3333_4444_5555_6666;
    send(hdr(MAGIC, 8'd5, 12'd3, 16'd1));
    send(a_b); send(b_b); send(c_b);
    idle(2);
    chk("s1_writes", obs_ch.size(), 3);
    for (int i = 0; i < obs_ch.size() && i < 3; i++) chk("s1_ch", obs_ch[i], 5);
    if (obs_d.size() == 3) begin
      chk("s1_d0", obs_d[0], a_b); chk("s1_d1", obs_d[1], b_b); chk("s1_d2", obs_d[2], c_b);
      chk("s1_done_pos", {obs_done[0], obs_done[1], obs_done[2]}, 3'b001);
    end
    chk("s1_frame_cnt", fcnt_o, 16'd1);
    chk("s1_done_count", n_done, 1);

    // Channel 7 with a ten-cycle almost-full stall after beat 2.
    $display("scenario ch7 len4 stall");
    clear_obs();
    d_b = 128'hD;
    send(hdr(MAGIC, 8'd7, 12'd4, 16'd2));
    send(128'h71); send(128'h72);
    pf[7] = 1'b1; vld = 1'b1; data = 128'h73;
    repeat (10) begin
      @(negedge clk); chk("s2_stall_rdy", rdy, 0);
      @(posedge clk); #1;
    end
    pf[7] = 1'b0;
    send(128'h73); send(128'h74);
    idle(2);
    chk("s2_writes", obs_ch.size(), 4);
    for (int i = 0; i < obs_d.size() && i < 4; i++) begin
      d_b = 128'h71 + 128'(i);
      chk("s2_order", obs_d[i], d_b);
      chk("s2_ch", obs_ch[i], 7);
    end
    chk("s2_done_count", n_done, 1);

    // Bad magic, out-of-range channel, then a good one-beat frame.
    $display("scenario header errors");
    do_reset();
    send(hdr(16'h1234, 8'd5, 12'd1, 16'd0));
    send(hdr(MAGIC, 8'd200, 12'd2, 16'd1));
    send(128'h201); send(128'h202);
    send(hdr(MAGIC, 8'd0, 12'd1, 16'd2));
    send(128'h300);
    idle(2);
    chk("s3_hdr_err", err_o, 16'd2);
    chk("s3_writes", obs_ch.size(), 1);
    if (obs_ch.size() == 1) begin
      chk("s3_ch", obs_ch[0], 0); chk("s3_d", obs_d[0], 128'h300);
    end
    chk("s3_frame_cnt", fcnt_o, 16'd2);

    // Sequence gap 10 -> 12.
    $display("scenario sequence gap");
    do_reset();
    send(hdr(MAGIC, 8'd1, 12'd1, 16'd10)); send(128'h1);
    idle(1);
    chk("s4_seq_first", seq_o, 0);
    send(hdr(MAGIC, 8'd1, 12'd1, 16'd12)); send(128'h2);
    idle(1);
    chk("s4_seq_set", seq_o, 1);
    idle(20);
    chk("s4_seq_held", seq_o, 1);
    do_reset();
    chk("s4_seq_cleared", seq_o, 0);

    // Reset in the middle of a five-beat frame.
    $display("scenario reset mid-frame");
    send(hdr(MAGIC, 8'd2, 12'd5, 16'd7)); send(128'h51);
    do_reset();
    send(hdr(MAGIC, 8'd3, 12'd1, 16'd9)); send(128'h61);
    idle(2);
    chk("s5_writes", obs_ch.size(), 1);
    if (obs_ch.size() == 1) chk("s5_ch", obs_ch[0], 3);
    chk("s5_frame_cnt", fcnt_o, 16'd9);
    chk("s5_hdr_err", err_o, 0);
    chk("s5_seq_err", seq_o, 0);

    // Empty frame followed back-to-back by a two-beat frame.
    $display("scenario empty frame then len2");
    clear_obs();
    t0 = cyc;
    send(hdr(MAGIC, 8'd1, 12'd0, 16'd10));
    send(hdr(MAGIC, 8'd4, 12'd2, 16'd10));
    send(128'h81); send(128'h82);
    chk("s6_cycles", cyc - t0, 4);
    idle(2);
    chk("s6_writes", obs_ch.size(), 2);
    chk("s6_done_count", n_done, 1);

    // Randomized frames with random backpressure.
    pf_random = 1'b1;
    fc_run = 16'd11;
    for (int f = 0; f < 300; f++) begin
      logic [15:0] mg;
      logic [7:0]  ch;
      int          len;
      mg  = MAGIC;
      if ($urandom % 10 == 0) begin
        mg = 16'($urandom);
        if (mg == MAGIC) mg = mg ^ 16'h1;
      end
      ch  = ($urandom % 8 == 0) ? 8'(104 + $urandom % 152) : 8'($urandom % 104);
      len = int'($urandom % 6);
      fc_run = ($urandom % 8 == 0) ? 16'($urandom) : fc_run + 16'd1;
      $display("frame %0d magic %h ch %0d len %0d fcnt %0d", f, mg, ch, len, fc_run);
      send(hdr(mg, ch, 12'(len), fc_run));
      if (mg == MAGIC) begin
        for (int b = 0; b < len; b++) begin
          if ($urandom % 3 == 0) idle(int'($urandom % 3));
          send(rnd128());
        end
      end
    end
    pf_random = 1'b0;
    pf = '0;
    idle(3);

    // Header error counter saturation.
    $display("scenario hdr_err saturation");
    do_reset();
    for (int i = 0; i < 65540; i++) send({16'h0000, 112'(i)});
    idle(2);
    chk("s8_hdr_err_sat", err_o, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ds_data_distributing.md
DS_DATA_DISTRIBUTING -- requirements
Module: ds_data_distributing

Interface
REQ-001 SHALL have parameter TOTAL_NUM, default 104, number of downstream channel caches.
REQ-002 SHALL have parameter HDR_MAGIC, default 16'hEB90, required header sync word.
REQ-003 SHALL have port sys_clk_i  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ds_flow_vld_i  input  1  merged downstream beat valid.
REQ-006 SHALL have port ds_flow_i  input  128  merged downstream beat data.
REQ-007 SHALL have port ds_flow_rdy_o  output  1  beat accepted when vld and rdy both high.
REQ-008 SHALL have port ds_timming_wr_en_o  output  TOTAL_NUM  one-hot per-channel cache write enable.
REQ-009 SHALL have port ds_timming_din_o  output  128  payload data, shared by all channel caches.
REQ-010 SHALL have port ds_timming_prog_full_i  input  TOTAL_NUM  per-channel cache almost-full.
REQ-011 SHALL have port frame_done_pluse_o  output  1  one-cycle pulse per completed frame.
REQ-012 SHALL have port frame_cnt_o  output  16  frame counter of last accepted header.
REQ-013 SHALL have port hdr_err_cnt_o  output  16  header error count, saturating at 16'hFFFF.
REQ-014 SHALL have port seq_err_o  output  1  sticky frame-sequence mismatch flag.

Function
REQ-015 Header beat fields SHALL be: [127:112] magic, [111:104] channel, [103:92] payload length in beats, [91:76] frame count, [75:0] ignored.
REQ-016 States SHALL be S_IDLE, S_PAYLOAD, S_DROP; reset state S_IDLE.
REQ-017 In S_IDLE, ds_flow_rdy_o SHALL be 1; each accepted beat is treated as a header.
REQ-018 Header with magic != HDR_MAGIC: stay S_IDLE, beat discarded, hdr_err_cnt_o +1.
REQ-019 Valid magic, channel >= TOTAL_NUM, length != 0: go S_DROP, hdr_err_cnt_o +1, length latched.
REQ-020 Valid magic, length == 0: stay S_IDLE, no write, no frame_done pulse, no error count.
REQ-021 Valid magic, channel < TOTAL_NUM, length != 0: latch channel, length, frame count; go S_PAYLOAD.
REQ-022 frame_cnt_o SHALL update on every header accepted per REQ-021.
REQ-023 seq_err_o SHALL set when a REQ-021 header's frame count != previous REQ-021 frame count + 1 (mod 2^16); first header after reset never flags; cleared only by reset.
REQ-024 In S_PAYLOAD, ds_flow_rdy_o SHALL equal !ds_timming_prog_full_i[latched channel], combinational.
REQ-025 Each accepted payload beat SHALL produce ds_timming_wr_en_o[channel]=1 and ds_timming_din_o=beat exactly one cycle later (registered, latency 1).
REQ-026 ds_timming_wr_en_o SHALL never have more than one bit set; all zero in cycles without a write.
REQ-027 A 12-bit beat counter SHALL count accepted payload beats; on the beat where count reaches length, return S_IDLE.
REQ-028 frame_done_pluse_o SHALL assert in the same cycle as the last payload write enable.
REQ-029 In S_DROP, ds_flow_rdy_o SHALL be 1; beats counted and discarded, no write; return S_IDLE after length beats, no frame_done pulse.
REQ-030 prog_full deassertion mid-frame SHALL resume acceptance with no beat lost or duplicated.
REQ-031 hdr_err_cnt_o SHALL hold at 16'hFFFF once reached.
REQ-032 Back-to-back frames SHALL be accepted with zero idle cycles between last payload beat and next header.

Reset
REQ-033 rst_i high SHALL asynchronously force: state S_IDLE, ds_flow_rdy_o 0, ds_timming_wr_en_o 0, ds_timming_din_o 0, frame_done_pluse_o 0, frame_cnt_o 0, hdr_err_cnt_o 0, seq_err_o 0, beat counter 0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame; after release the next beat is parsed as a header.
REQ-035 ds_flow_rdy_o SHALL become 1 on the first clock edge after rst_i deasserts.

Verification
REQ-036 Header ch=5, len=3, fcnt=1, then 3 beats A,B,C -> wr_en bit 5 for 3 cycles with A,B,C, frame_done with C write, frame_cnt_o=1.
REQ-037 Header ch=7, len=4; prog_full[7]=1 for 10 cycles after beat 2 -> rdy low 10 cycles, exactly 4 writes, order preserved.
REQ-038 Magic 16'h1234, then header ch=200, len=2 plus 2 beats, then valid frame ch=0 len=1 -> hdr_err_cnt_o=2, no writes for first two, one write on channel 0.
REQ-039 Headers fcnt=10 then 12, both valid -> seq_err_o=1 after second header, held until reset.
REQ-040 rst_i pulsed after beat 1 of len=5 frame, then header ch=3 len=1 plus beat -> single write on channel 3, all counters restarted from 0.
REQ-041 Header len=0 followed immediately by valid len=2 frame -> no pulse for first, both payload beats written, no idle cycles.
